// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus definitions for the round-robin arbiter: master count, active-low levels,
// owner index type and arbiter state encodings.
package bus_rr_arbiter_pkg;

  localparam int unsigned BUS_MASTER_CH = 4;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef logic [1:0] BusOwnerBus;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT   = 2'd1,
    ARB_TIMEOUT = 2'd2
  } arb_state_t;

  function automatic logic [BUS_MASTER_CH-1:0] owner_onehot(input BusOwnerBus idx);
    owner_onehot      = '0;
    owner_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant and watchdog signals between the bus masters and the arbiter.
interface bus_rr_arbiter_if;
  import bus_rr_arbiter_pkg::*;

  logic [BUS_MASTER_CH-1:0] m_req_;
  logic                     s_as_;
  logic                     s_rdy_;
  logic                     err_clr;
  logic [BUS_MASTER_CH-1:0] m_grnt_;
  BusOwnerBus               owner;
  logic                     wdt_rdy_;
  logic                     bus_err;
  BusOwnerBus               err_master;

  modport master (
    output m_req_, s_as_, s_rdy_, err_clr,
    input  m_grnt_, owner, wdt_rdy_, bus_err, err_master
  );

  modport slave (
    input  m_req_, s_as_, s_rdy_, err_clr,
    output m_grnt_, owner, wdt_rdy_, bus_err, err_master
  );

endinterface

// File: rtl/bus_rr_pick.sv
// Combinational 4-way rotating priority picker: first requester after `last`,
// wrapping, with `last` itself lowest; masked-out requesters are ignored.
module bus_rr_pick
  import bus_rr_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req,
  input  BusOwnerBus               last,
  input  logic [BUS_MASTER_CH-1:0] excl,
  output BusOwnerBus               winner,
  output logic                     valid
);

  logic [BUS_MASTER_CH-1:0] cand;
  BusOwnerBus               idx;

  always_comb begin
    cand   = req & ~excl;
    winner = last;
    valid  = 1'b0;
    idx    = last;
    // Scan from lowest to highest priority so the nearest requester overwrites the rest.
    for (int unsigned k = BUS_MASTER_CH; k >= 1; k--) begin
      idx = last + BusOwnerBus'(k);
      if (cand[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with a fairness hold limit and a bus watchdog that forces
// completion of accesses whose slave never answers.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_HOLD       = 64,
  parameter int unsigned CNT_W          = 9
) (
  input  logic             clk,
  input  logic             reset,
  bus_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] WDT_LIMIT  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic             HOLD_EN    = (MAX_HOLD != 0);

  arb_state_t               state, state_nx;
  BusOwnerBus               owner_q, owner_nx;
  BusOwnerBus               err_master_q, err_master_nx;
  logic [BUS_MASTER_CH-1:0] grnt_q, grnt_nx;
  logic                     wdt_rdy_q, wdt_rdy_nx;
  logic                     bus_err_q, bus_err_nx;
  logic [CNT_W-1:0]         hold_cnt, hold_nx;
  logic [CNT_W-1:0]         wdt_cnt, wdt_nx;

  logic [BUS_MASTER_CH-1:0] req;
  logic [BUS_MASTER_CH-1:0] excl;
  BusOwnerBus               winner;
  logic                     valid;
  logic                     others_req;
  logic                     wdt_busy;
  logic                     err_set;

  assign req        = ~bus.m_req_;
  assign excl       = (state == ARB_GRANT) ? owner_onehot(owner_q) : '0;
  assign others_req = |(req & ~owner_onehot(owner_q));
  assign wdt_busy   = (bus.s_as_ == ENABLE_) && (bus.s_rdy_ == DISABLE_);

  bus_rr_pick u_pick (
    .req    (req),
    .last   (owner_q),
    .excl   (excl),
    .winner (winner),
    .valid  (valid)
  );

  always_comb begin
    state_nx      = state;
    owner_nx      = owner_q;
    grnt_nx       = grnt_q;
    wdt_rdy_nx    = DISABLE_;
    err_master_nx = err_master_q;
    hold_nx       = hold_cnt;
    wdt_nx        = wdt_cnt;
    err_set       = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        hold_nx = '0;
        wdt_nx  = '0;
        grnt_nx = '1;
        if (valid) begin
          state_nx = ARB_GRANT;
          owner_nx = winner;
          grnt_nx  = ~owner_onehot(winner);
        end
      end
      ARB_GRANT: begin
        // A real s_rdy_ on the limit cycle makes wdt_busy false, so it beats the timeout.
        if (wdt_busy && (wdt_cnt == WDT_LIMIT)) begin
          state_nx      = ARB_TIMEOUT;
          wdt_rdy_nx    = ENABLE_;
          err_set       = 1'b1;
          err_master_nx = owner_q;
          wdt_nx        = '0;
        end else if (!req[owner_q] ||
                     (HOLD_EN && others_req && (bus.s_as_ == DISABLE_) &&
                      (hold_cnt >= HOLD_LIMIT))) begin
          hold_nx = '0;
          wdt_nx  = '0;
          if (valid) begin
            owner_nx = winner;
            grnt_nx  = ~owner_onehot(winner);
          end else begin
            state_nx = ARB_IDLE;
            grnt_nx  = '1;
          end
        end else begin
          wdt_nx  = !wdt_busy ? '0 : (&wdt_cnt) ? wdt_cnt : wdt_cnt + 1'b1;
          hold_nx = !others_req ? '0 : (&hold_cnt) ? hold_cnt : hold_cnt + 1'b1;
        end
      end
      ARB_TIMEOUT: begin
        state_nx = ARB_GRANT;
        wdt_nx   = '0;
      end
      default: begin
        state_nx = ARB_IDLE;
        grnt_nx  = '1;
      end
    endcase

    bus_err_nx = err_set | (bus_err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB_IDLE;
      owner_q      <= '0;
      grnt_q       <= '1;
      wdt_rdy_q    <= DISABLE_;
      bus_err_q    <= 1'b0;
      err_master_q <= '0;
      hold_cnt     <= '0;
      wdt_cnt      <= '0;
    end else begin
      state        <= state_nx;
      owner_q      <= owner_nx;
      grnt_q       <= grnt_nx;
      wdt_rdy_q    <= wdt_rdy_nx;
      bus_err_q    <= bus_err_nx;
      err_master_q <= err_master_nx;
      hold_cnt     <= hold_nx;
      wdt_cnt      <= wdt_nx;
    end
  end

  assign bus.m_grnt_    = grnt_q;
  assign bus.owner      = owner_q;
  assign bus.wdt_rdy_   = wdt_rdy_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.err_master = err_master_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed self-checking bench for bus_rr_arbiter (TIMEOUT_CYCLES=8, MAX_HOLD=4).
module tb_bus_rr_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  bus_rr_arbiter_if bus ();

  bus_rr_arbiter #(
    .TIMEOUT_CYCLES (8),
    .MAX_HOLD       (4),
    .CNT_W          (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] grnt, input logic [1:0] own,
                         input logic wdt, input logic err, input logic [1:0] errm);
    chk({tag, ".grnt"}, bus.m_grnt_, grnt);
    chk({tag, ".owner"}, {2'b00, bus.owner}, {2'b00, own});
    chk({tag, ".wdt_rdy_"}, {3'b000, bus.wdt_rdy_}, {3'b000, wdt});
    chk({tag, ".bus_err"}, {3'b000, bus.bus_err}, {3'b000, err});
    chk({tag, ".err_master"}, {2'b00, bus.err_master}, {2'b00, errm});
  endtask

  // One-cold-or-all-high grant invariant, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      assert ($countones(~bus.m_grnt_) <= 1) else begin
        n_err++;
        $error("FAIL grant_onecold observed=%b expected=at most one low", bus.m_grnt_);
      end
    end
  end

  initial begin
    bus.m_req_  = 4'b1111;
    bus.s_as_   = 1'b1;
    bus.s_rdy_  = 1'b1;
    bus.err_clr = 1'b0;

    step(2);
    chk_all("reset", 4'b1111, 2'd0, 1'b1, 1'b0, 2'd0);
    reset = 1'b0;

    // Basic grant and release
    bus.m_req_ = 4'b1110;
    step(1);
    chk_all("t1_grant", 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b1111;
    step(1);
    chk_all("t1_release", 4'b1111, 2'd0, 1'b1, 1'b0, 2'd0);

    // Rotation 2,3,0,1 with no idle cycle
    bus.m_req_ = 4'b1101;
    step(1);
    chk_all("t2_own1", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b0000;
    step(1);
    chk("t2_hold1", bus.m_grnt_, 4'b1101);
    bus.m_req_ = 4'b0010;
    step(1);
    chk_all("t2_to2", 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b0100;
    step(1);
    chk_all("t2_to3", 4'b0111, 2'd3, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b1100;
    step(1);
    chk_all("t2_to0", 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b1101;
    step(1);
    chk_all("t2_to1", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b1111;
    step(1);
    chk_all("t2_idle", 4'b1111, 2'd1, 1'b1, 1'b0, 2'd0);

    // Hold limit revoke
    bus.m_req_ = 4'b1110;
    step(1);
    chk_all("t3_own0", 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t3_hold0", bus.m_grnt_, 4'b1110);
    end
    step(1);
    chk_all("t3_revoke_to2", 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0);
    bus.s_as_  = 1'b0;
    bus.s_rdy_ = 1'b0;
    step(8);
    chk_all("t3_no_revoke_as", 4'b1011, 2'd2, 1'b1, 1'b0, 2'd0);
    bus.s_as_ = 1'b1;
    step(1);
    chk_all("t3_revoke_to0", 4'b1110, 2'd0, 1'b1, 1'b0, 2'd0);
    bus.m_req_ = 4'b1111;
    bus.s_rdy_ = 1'b1;
    step(1);
    chk("t3_idle", bus.m_grnt_, 4'b1111);

    // Watchdog timeout on a dead slave
    bus.m_req_ = 4'b1101;
    step(1);
    chk_all("t4_own1", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0);
    bus.s_as_ = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("t4_wdt_quiet", {3'b000, bus.wdt_rdy_}, 4'd1);
    end
    step(1);
    chk_all("t4_timeout", 4'b1101, 2'd1, 1'b0, 1'b1, 2'd1);
    bus.s_as_ = 1'b1;
    step(1);
    chk_all("t4_after", 4'b1101, 2'd1, 1'b1, 1'b1, 2'd1);
    bus.err_clr = 1'b1;
    step(1);
    bus.err_clr = 1'b0;
    chk_all("t4_err_clr", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd1);

    // Genuine ready on the limit cycle wins
    bus.s_as_ = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("t5_wdt_quiet", {3'b000, bus.wdt_rdy_}, 4'd1);
    end
    bus.s_rdy_ = 1'b0;
    step(1);
    chk_all("t5_limit_rdy", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd1);
    bus.s_as_  = 1'b1;
    bus.s_rdy_ = 1'b1;
    step(1);
    chk_all("t5_after", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd1);

    // Asynchronous reset mid-transaction
    bus.m_req_ = 4'b0101;
    bus.s_as_  = 1'b0;
    step(2);
    chk("t6_pre", bus.m_grnt_, 4'b1101);
    #2 reset = 1'b1;
    #1;
    chk_all("t6_async_reset", 4'b1111, 2'd0, 1'b1, 1'b0, 2'd0);
    #3 reset = 1'b0;
    bus.s_as_ = 1'b1;
    step(1);
    chk_all("t6_rearb", 4'b1101, 2'd1, 1'b1, 1'b0, 2'd0);

    bus.m_req_ = 4'b1111;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
